// File: rtl/gpu_pkg.sv
// Shared GPU types: AXI write response codes and the texture upload FSM states.
// Pure declarations; no latency or backpressure of its own.
package gpu_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        RESP
    } texture_writer_state_t;

endpackage

// File: rtl/texture_writer_if.sv
// Command, data stream and AXI4-Lite write channels of the texture uploader.
// master = uploader side, slave = loader/stream/RAM side; all handshakes are valid/ready.
interface texture_writer_if #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  cmd_valid;
    logic                  cmd_ready;

    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        input  cmd_addr, cmd_len, cmd_valid,
        output cmd_ready,
        input  s_data, s_valid,
        output s_ready,
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output cmd_addr, cmd_len, cmd_valid,
        input  cmd_ready,
        output s_data, s_valid,
        input  s_ready,
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/texture_writer.sv
// Texture upload AXI4-Lite write master: one write per stream word, min 3 cycles/word, one outstanding.
// Stalls freely on stream, AW, W and B; valids held until their own handshake.
module texture_writer
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 22,
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int ADDR_STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    texture_writer_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             err
);

    texture_writer_state_t state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  done_q;
    logic                  err_q;
    logic                  aw_hs;
    logic                  w_hs;

    assign aw_hs = awvalid_q && bus.awready;
    assign w_hs  = wvalid_q && bus.wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            remaining <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q    <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                        err_q     <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (bus.s_valid) begin
                        wdata_q   <= bus.s_data;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // A dropped valid doubles as the "channel finished" flag.
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.bvalid) begin
                        err_q     <= err_q | (axi_resp_t'(bus.bresp) != OKAY);
                        addr_q    <= addr_q + ADDR_WIDTH'(ADDR_STRIDE);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.s_ready   = (state == FETCH);
    assign bus.bready    = (state == RESP);
    assign bus.awaddr    = addr_q;
    assign bus.awprot    = 3'b000;
    assign bus.awvalid   = awvalid_q;
    assign bus.wdata     = wdata_q;
    assign bus.wvalid    = wvalid_q;
    assign busy          = (state != IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_texture_writer.sv
// Directed bench for texture_writer: stream source and AXI4-Lite slave models with per-run delays/responses,
// per-command checks of addresses, data, timing, done pulse and err.
module tb_texture_writer;
    import gpu_pkg::*;

    logic clk;
    logic rst;
    logic busy;
    logic done;
    logic err;

    texture_writer_if #(.ADDR_WIDTH(22), .DATA_WIDTH(32), .LEN_WIDTH(16)) tw_if ();

    texture_writer dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (tw_if),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-command configuration, written only by the main sequence.
    logic [31:0] s_mem [8];
    logic [1:0]  resp_tab [8];
    int          s_n;
    int          aw_delay;
    int          w_delay;
    int          cfg_gen;

    // Slave-model state, written only by the slave process.
    logic [21:0] aw_log [$];
    logic [31:0] w_log [$];
    int          proto_err = 0;
    int          sl_gen = -1;
    int          aw_cnt, w_cnt, b_cnt, aw_wait, w_wait;
    bit          aw_active, w_active;
    logic [21:0] aw_hold;
    logic [31:0] w_hold;

    // Stream-source state.
    int s_seen = -1;
    int s_idx;
    bit s_pend;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic proto_note(input string msg);
        proto_err++;
        $display("protocol violation at %0t: %s", $time, msg);
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Stream source: word i stays on s_data until the edge that consumes it.
    always @(negedge clk) begin
        if (rst || s_seen != cfg_gen) begin
            s_seen = cfg_gen;
            s_idx  = 0;
            s_pend = 1'b0;
        end else if (s_pend) begin
            s_idx++;
            s_pend = 1'b0;
        end
        tw_if.s_valid = (s_idx < s_n);
        tw_if.s_data  = s_mem[s_idx % 8];
        if (tw_if.s_valid && tw_if.s_ready) s_pend = 1'b1;
    end

    // AXI4-Lite slave: readies after aw_delay/w_delay cycles of valid, B raised as soon as AW and W are in.
    always @(negedge clk) begin
        if (rst || sl_gen != cfg_gen) begin
            sl_gen    = cfg_gen;
            aw_active = 1'b0;
            w_active  = 1'b0;
            aw_cnt    = 0;
            w_cnt     = 0;
            b_cnt     = 0;
            aw_log.delete();
            w_log.delete();
            tw_if.awready = 1'b0;
            tw_if.wready  = 1'b0;
            tw_if.bvalid  = 1'b0;
            tw_if.bresp   = 2'b00;
        end else begin
            if (tw_if.awvalid) begin
                if (!aw_active) begin
                    aw_active = 1'b1;
                    aw_hold   = tw_if.awaddr;
                    aw_wait   = 0;
                end else if (tw_if.awaddr !== aw_hold) begin
                    proto_note("awaddr changed while awvalid");
                end
                if (tw_if.awprot !== 3'b000) proto_note("awprot not zero");
                tw_if.awready = (aw_wait >= aw_delay);
                aw_wait++;
                if (tw_if.awready) begin
                    aw_log.push_back(tw_if.awaddr);
                    aw_cnt++;
                    aw_active = 1'b0;
                end
            end else begin
                if (aw_active) proto_note("awvalid dropped before handshake");
                tw_if.awready = 1'b0;
            end
            if (tw_if.wvalid) begin
                if (!w_active) begin
                    w_active = 1'b1;
                    w_hold   = tw_if.wdata;
                    w_wait   = 0;
                end else if (tw_if.wdata !== w_hold) begin
                    proto_note("wdata changed while wvalid");
                end
                tw_if.wready = (w_wait >= w_delay);
                w_wait++;
                if (tw_if.wready) begin
                    w_log.push_back(tw_if.wdata);
                    w_cnt++;
                    w_active = 1'b0;
                end
            end else begin
                if (w_active) proto_note("wvalid dropped before handshake");
                tw_if.wready = 1'b0;
            end
            if (tw_if.bready && !(aw_cnt > b_cnt && w_cnt > b_cnt))
                proto_note("bready before both AW and W handshakes");
            tw_if.bvalid = (aw_cnt > b_cnt) && (w_cnt > b_cnt);
            tw_if.bresp  = resp_tab[b_cnt % 8];
            if (tw_if.bvalid && tw_if.bready) b_cnt++;
        end
    end

    task automatic run_cmd(input logic [21:0] addr, input int len, input int ad, input int wd,
                           input logic exp_err, input bit junk);
        int          done_k;
        int          pulses;
        int          exp_k;
        int          mx;
        logic        err_at_done;
        bit          rdy_low;
        logic [21:0] a;
        aw_delay = ad;
        w_delay  = wd;
        s_n      = len;
        cfg_gen++;
        tick;
        tw_if.cmd_addr  = addr;
        tw_if.cmd_len   = 16'(len);
        tw_if.cmd_valid = 1'b1;
        check("cmd_ready_idle", tw_if.cmd_ready, 1);
        tick;
        // Optionally keep a bogus command on the bus while busy; it must be ignored.
        tw_if.cmd_valid = junk;
        tw_if.cmd_addr  = 22'h155555;
        tw_if.cmd_len   = 16'd7;
        done_k      = -1;
        pulses      = 0;
        err_at_done = 1'b0;
        rdy_low     = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (c == 0) check("err_cleared_on_accept", err, 0);
            if (c == 5) tw_if.cmd_valid = 1'b0;
            if (done) begin
                pulses++;
                if (done_k < 0) begin
                    done_k      = c;
                    err_at_done = err;
                end
            end
            if (!tw_if.cmd_ready) rdy_low = 1'b1;
            if (done_k >= 0 && c >= done_k + 3) break;
            tick;
        end
        tw_if.cmd_valid = 1'b0;
        mx    = (ad > wd) ? ad : wd;
        exp_k = len * (3 + mx);
        check("done_cycle", done_k, exp_k);
        check("done_pulses", pulses, 1);
        check("err_at_done", err_at_done, exp_err);
        check("busy_after_done", busy, 0);
        check("cmd_ready_dropped", rdy_low, (len != 0));
        check("aw_count", aw_log.size(), len);
        check("w_count", w_log.size(), len);
        for (int i = 0; i < len && i < aw_log.size() && i < w_log.size(); i++) begin
            a = addr + 22'(i);
            check("awaddr", aw_log[i], a);
            check("wdata", w_log[i], s_mem[i]);
        end
    endtask

    initial begin
        bit seen;
        rst             = 1'b1;
        cfg_gen         = 0;
        aw_delay        = 0;
        w_delay         = 0;
        s_n             = 0;
        tw_if.cmd_valid = 1'b0;
        tw_if.cmd_addr  = '0;
        tw_if.cmd_len   = '0;
        for (int i = 0; i < 8; i++) begin
            s_mem[i]    = '0;
            resp_tab[i] = OKAY;
        end
        #2;
        check("rst_cmd_ready", tw_if.cmd_ready, 1);
        check("rst_s_ready", tw_if.s_ready, 0);
        check("rst_bready", tw_if.bready, 0);
        check("rst_busy", busy, 0);
        check("rst_awvalid", tw_if.awvalid, 0);
        check("rst_wvalid", tw_if.wvalid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_awaddr", tw_if.awaddr, 0);
        check("rst_wdata", tw_if.wdata, 0);
        check("rst_awprot", tw_if.awprot, 0);
        tick;
        tick;
        rst = 1'b0;

        // Full-speed upload of four words, with a bogus command held during the run.
        s_mem[0] = 32'hA; s_mem[1] = 32'hB; s_mem[2] = 32'hC; s_mem[3] = 32'hD;
        run_cmd(22'h100, 4, 0, 0, 1'b0, 1'b1);

        // Zero-length command.
        run_cmd(22'h0AB, 0, 0, 0, 1'b0, 1'b0);

        // Slow slave, AW late then W late.
        s_mem[0] = 32'h11111111; s_mem[1] = 32'h22222222;
        run_cmd(22'h2000, 2, 3, 1, 1'b0, 1'b0);
        s_mem[0] = 32'h33333333; s_mem[1] = 32'h44444444;
        run_cmd(22'h3000, 2, 1, 3, 1'b0, 1'b0);

        // Error on the middle word: all words still written, err sticky.
        s_mem[0] = 32'hDEAD0001; s_mem[1] = 32'hDEAD0002; s_mem[2] = 32'hDEAD0003;
        resp_tab[1] = SLVERR;
        run_cmd(22'h0040, 3, 0, 0, 1'b1, 1'b0);
        resp_tab[1] = OKAY;
        run_cmd(22'h0050, 0, 0, 0, 1'b0, 1'b0);

        // Address counter wraps at the top of the texel space.
        s_mem[0] = 32'h5A5A5A5A; s_mem[1] = 32'hA5A5A5A5;
        run_cmd(22'h3FFFFF, 2, 0, 0, 1'b0, 1'b0);

        // Reset while a write is in flight.
        aw_delay = 5;
        w_delay  = 0;
        s_n      = 3;
        cfg_gen++;
        tick;
        tw_if.cmd_addr  = 22'h300;
        tw_if.cmd_len   = 16'd3;
        tw_if.cmd_valid = 1'b1;
        tick;
        tw_if.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (tw_if.awvalid) seen = 1'b1;
            else tick;
        end
        check("awvalid_before_reset", seen, 1);
        #1 rst = 1'b1;
        #1;
        check("reset_awvalid", tw_if.awvalid, 0);
        check("reset_wvalid", tw_if.wvalid, 0);
        check("reset_busy", busy, 0);
        check("reset_cmd_ready", tw_if.cmd_ready, 1);
        check("reset_bready", tw_if.bready, 0);
        tick;
        rst = 1'b0;
        s_mem[0] = 32'h0BADF00D; s_mem[1] = 32'h12345678;
        run_cmd(22'h200, 2, 0, 0, 1'b0, 1'b0);

        check("protocol", proto_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
